// File: rtl/logs_pwm_demod.sv
// Integrate-and-dump demodulator: counts PWM ones over 2^WIN_LOG2-cycle windows into a valid/ready sample stream.
// Define LOGS_PWM_DEMOD_AVG_EN to emit the average of each pair of consecutive windows.
module logs_pwm_demod #(
    parameter int WIN_LOG2 = 8,
    parameter int SW       = WIN_LOG2 + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pwm_in,
    output logic [SW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          overrun,
    input  logic          clr_overrun
);
    localparam logic [WIN_LOG2-1:0] LAST = '1;

    logic                sync_0;
    logic                sync_1;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [SW-1:0]       accum;
    logic [SW-1:0]       cur;
    logic [SW-1:0]       cand;
    logic                dump;
    logic                emit;
    logic                drop;

    assign dump = (win_cnt == LAST);
    assign cur  = accum + {{(SW-1){1'b0}}, sync_1};

`ifdef LOGS_PWM_DEMOD_AVG_EN
    logic [SW-1:0] prev;
    logic          have_prev;
    logic [SW:0]   avg_sum;

    assign avg_sum = {1'b0, prev} + {1'b0, cur};
    assign cand    = avg_sum[SW:1];
    // The very first window only primes prev; nothing is emitted for it.
    assign emit    = have_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (dump) begin
            prev      <= cur;
            have_prev <= 1'b1;
        end
    end
`else
    assign cand = cur;
    assign emit = 1'b1;
`endif

    // Handshake: a transfer occurs when sample_valid && sample_ready in the same
    // cycle; sample is held stable while valid and untransferred, and
    // sample_ready has no effect while sample_valid is low.
    assign drop = dump && emit && sample_valid && !sample_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            win_cnt <= '0;
            accum   <= '0;
        end else begin
            sync_0  <= pwm_in;
            sync_1  <= sync_0;
            win_cnt <= win_cnt + 1'b1;
            accum   <= dump ? '0 : cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (dump && emit) begin
                if (!sample_valid || sample_ready) begin
                    sample       <= cand;
                    sample_valid <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // A new drop takes priority over a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule
